// File: rtl/cu_data_write_pairing_engine.sv
// CU data write pairing engine: joins 64B read-data halves by tag into
// 128B lines, queues them, and issues cmd+data_0 / data_1 write beats.
module cu_data_write_pairing_engine #(
  parameter int SLOTS         = 8,
  parameter int TAG_W         = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int ALFULL_MARGIN = 4,
  parameter int SIZE_W        = 32
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              enabled_in,
  input  logic [63:0]       array_receive_in,
  input  logic              data_in_valid,
  input  logic              data_in_half,
  input  logic [TAG_W-1:0]  data_in_tag,
  input  logic [63:0]       data_in_offset,
  input  logic [SIZE_W-1:0] data_in_real_size,
  input  logic [511:0]      data_in_payload,
  input  logic              write_buffer_alfull,
  output logic              write_cmd_valid,
  output logic [63:0]       write_cmd_address,
  output logic [SIZE_W-1:0] write_cmd_real_size,
  output logic              write_data_valid,
  output logic              write_data_half,
  output logic [511:0]      write_data_payload,
  output logic              pairing_alfull,
  output logic [SIZE_W-1:0] write_job_counter_done,
  output logic [2:0]        error_flags
);

  localparam int IW = $clog2(SLOTS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EMIT0, S_EMIT1} state_t;

  logic              r_en;
  logic              r_in_valid;
  logic              r_in_half;
  logic [TAG_W-1:0]  r_in_tag;
  logic [63:0]       r_in_off;
  logic [SIZE_W-1:0] r_in_size;
  logic [511:0]      r_in_pl;

  logic [SLOTS-1:0]  r_sv, r_sh0, r_sh1;
  logic [TAG_W-1:0]  r_stag  [SLOTS];
  logic [63:0]       r_soff  [SLOTS];
  logic [SIZE_W-1:0] r_ssize [SLOTS];
  logic [511:0]      r_sd0   [SLOTS];
  logic [511:0]      r_sd1   [SLOTS];

  logic [63:0]       r_foff  [FIFO_DEPTH];
  logic [SIZE_W-1:0] r_fsize [FIFO_DEPTH];
  logic [511:0]      r_fd0   [FIFO_DEPTH];
  logic [511:0]      r_fd1   [FIFO_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;

  state_t            r_state;
  logic              r_cmd_valid;
  logic [63:0]       r_addr;
  logic [SIZE_W-1:0] r_size;
  logic              r_dvalid;
  logic              r_dhalf;
  logic [511:0]      r_pl;
  logic [511:0]      r_d1;
  logic [SIZE_W-1:0] r_done;
  logic [2:0]        r_err;
  logic              r_palfull;

  logic [IW-1:0]     w_s;
  logic              w_hit, w_have;
  logic              w_new, w_fill, w_dup, w_coll;
  logic              w_full, w_pop, w_wr, w_ovf;
  logic [511:0]      w_pd0, w_pd1;

  assign w_s    = r_in_tag[IW-1:0];
  assign w_hit  = r_sv[w_s] && (r_stag[w_s] == r_in_tag);
  assign w_have = r_in_half ? r_sh1[w_s] : r_sh0[w_s];
  assign w_new  = r_in_valid && !r_sv[w_s];
  assign w_fill = r_in_valid && w_hit && !w_have;
  assign w_dup  = r_in_valid && w_hit && w_have;
  assign w_coll = r_in_valid && r_sv[w_s] && !w_hit;
  assign w_pd0  = r_in_half ? r_sd0[w_s] : r_in_pl;
  assign w_pd1  = r_in_half ? r_in_pl : r_sd1[w_s];

  assign w_full = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop  = r_en && (r_cnt != '0) && !write_buffer_alfull
               && (r_state != S_EMIT0);
  assign w_wr   = w_fill && (!w_full || w_pop);
  assign w_ovf  = w_fill && w_full && !w_pop;

  // Registered enable and one-cycle input beat stage
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_en       <= 1'b0;
      r_in_valid <= 1'b0;
      r_in_half  <= 1'b0;
      r_in_tag   <= '0;
      r_in_off   <= '0;
      r_in_size  <= '0;
      r_in_pl    <= '0;
    end else begin
      r_en       <= enabled_in;
      r_in_valid <= r_en && data_in_valid;
      if (r_en && data_in_valid) begin
        r_in_half <= data_in_half;
        r_in_tag  <= data_in_tag;
        r_in_off  <= data_in_offset;
        r_in_size <= data_in_real_size;
        r_in_pl   <= data_in_payload;
      end
    end
  end

  // Pairing table: open a slot on the first half, release it on completion
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_sv  <= '0;
      r_sh0 <= '0;
      r_sh1 <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_stag[i]  <= '0;
        r_soff[i]  <= '0;
        r_ssize[i] <= '0;
        r_sd0[i]   <= '0;
        r_sd1[i]   <= '0;
      end
    end else begin
      if (w_new) begin
        r_sv[w_s]    <= 1'b1;
        r_stag[w_s]  <= r_in_tag;
        r_soff[w_s]  <= r_in_off;
        r_ssize[w_s] <= r_in_size;
        if (r_in_half) r_sh1[w_s] <= 1'b1;
        else           r_sh0[w_s] <= 1'b1;
      end else if (w_fill) begin
        r_sv[w_s]  <= 1'b0;
        r_sh0[w_s] <= 1'b0;
        r_sh1[w_s] <= 1'b0;
      end
      if (w_new || w_dup) begin
        if (r_in_half) r_sd1[w_s] <= r_in_pl;
        else           r_sd0[w_s] <= r_in_pl;
      end
    end
  end

  // Completed-line FIFO storage
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_foff[r_wp]  <= r_soff[w_s];
      r_fsize[r_wp] <= r_ssize[w_s];
      r_fd0[r_wp]   <= w_pd0;
      r_fd1[r_wp]   <= w_pd1;
    end
  end

  // FIFO pointers, occupancy, almost-full status and sticky errors
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_palfull <= 1'b0;
      r_err     <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      if (w_wr && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_wr && w_pop) r_cnt <= r_cnt - CW'(1);
      r_palfull <= (r_cnt >= CW'(FIFO_DEPTH - ALFULL_MARGIN));
      r_err     <= r_err | {w_ovf, w_coll, w_dup};
    end
  end

  // Emission FSM: EMIT0 carries cmd + data_0, EMIT1 carries data_1
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_dvalid    <= 1'b0;
      r_dhalf     <= 1'b0;
      r_pl        <= '0;
      r_d1        <= '0;
      r_done      <= '0;
    end else if (r_en) begin
      unique case (r_state)
        S_EMIT0: begin
          r_state     <= S_EMIT1;
          r_cmd_valid <= 1'b0;
          r_dvalid    <= 1'b1;
          r_dhalf     <= 1'b1;
          r_pl        <= r_d1;
        end
        default: begin
          if (w_pop) begin
            r_state     <= S_EMIT0;
            r_cmd_valid <= 1'b1;
            r_addr      <= array_receive_in + r_foff[r_rp];
            r_size      <= r_fsize[r_rp];
            r_dvalid    <= 1'b1;
            r_dhalf     <= 1'b0;
            r_pl        <= r_fd0[r_rp];
            r_d1        <= r_fd1[r_rp];
            r_done      <= r_done + r_fsize[r_rp];
          end else begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_dvalid    <= 1'b0;
            r_dhalf     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign write_cmd_valid        = r_cmd_valid && r_en;
  assign write_cmd_address      = r_en ? r_addr : '0;
  assign write_cmd_real_size    = r_en ? r_size : '0;
  assign write_data_valid       = r_dvalid && r_en;
  assign write_data_half        = r_dhalf && r_en;
  assign write_data_payload     = r_en ? r_pl : '0;
  assign pairing_alfull         = r_palfull;
  assign write_job_counter_done = r_done;
  assign error_flags            = r_err;

endmodule

// File: tb/tb_cu_data_write_pairing_engine.sv
// Directed bench for cu_data_write_pairing_engine.
// Hand-computed expectations for pairing, emission, errors, enable, reset.
module tb_cu_data_write_pairing_engine;

  logic         clock;
  logic         rstn;
  logic         enabled_in;
  logic [63:0]  array_receive_in;
  logic         data_in_valid;
  logic         data_in_half;
  logic [7:0]   data_in_tag;
  logic [63:0]  data_in_offset;
  logic [31:0]  data_in_real_size;
  logic [511:0] data_in_payload;
  logic         write_buffer_alfull;
  logic         write_cmd_valid;
  logic [63:0]  write_cmd_address;
  logic [31:0]  write_cmd_real_size;
  logic         write_data_valid;
  logic         write_data_half;
  logic [511:0] write_data_payload;
  logic         pairing_alfull;
  logic [31:0]  write_job_counter_done;
  logic [2:0]   error_flags;

  int n_chk  = 0;
  int n_fail = 0;

  cu_data_write_pairing_engine dut (
    .clock                  (clock),
    .rstn                   (rstn),
    .enabled_in             (enabled_in),
    .array_receive_in       (array_receive_in),
    .data_in_valid          (data_in_valid),
    .data_in_half           (data_in_half),
    .data_in_tag            (data_in_tag),
    .data_in_offset         (data_in_offset),
    .data_in_real_size      (data_in_real_size),
    .data_in_payload        (data_in_payload),
    .write_buffer_alfull    (write_buffer_alfull),
    .write_cmd_valid        (write_cmd_valid),
    .write_cmd_address      (write_cmd_address),
    .write_cmd_real_size    (write_cmd_real_size),
    .write_data_valid       (write_data_valid),
    .write_data_half        (write_data_half),
    .write_data_payload     (write_data_payload),
    .pairing_alfull         (pairing_alfull),
    .write_job_counter_done (write_job_counter_done),
    .error_flags            (error_flags)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [511:0] act,
                     input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] mkpl(input logic [7:0] t, input logic h);
    return {16{t, 7'h0, h, 16'hBEEF}};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic h, input logic [7:0] t,
                           input logic [63:0] off, input logic [31:0] sz,
                           input logic [511:0] pl);
    data_in_valid     = 1'b1;
    data_in_half      = h;
    data_in_tag       = t;
    data_in_offset    = off;
    data_in_real_size = sz;
    data_in_payload   = pl;
    tick();
  endtask

  task automatic send_line(input logic [7:0] t, input logic [63:0] off,
                           input logic [31:0] sz);
    send_beat(1'b0, t, off, sz, mkpl(t, 1'b0));
    send_beat(1'b1, t, off, sz, mkpl(t, 1'b1));
    data_in_valid = 1'b0;
  endtask

  task automatic expect_line(input string nm, input logic [63:0] addr,
                             input logic [31:0] sz, input logic [511:0] d0,
                             input logic [511:0] d1);
    int k = 0;
    while (!write_cmd_valid && k < 20) begin
      tick();
      k++;
    end
    chk({nm, "_seen"}, write_cmd_valid, 1);
    chk({nm, "_addr"}, write_cmd_address, addr);
    chk({nm, "_size"}, write_cmd_real_size, sz);
    chk({nm, "_e0"}, {write_data_valid, write_data_half}, 2'b10);
    chk({nm, "_d0"}, write_data_payload, d0);
    tick();
    chk({nm, "_e1"}, {write_cmd_valid, write_data_valid, write_data_half},
        3'b011);
    chk({nm, "_d1"}, write_data_payload, d1);
  endtask

  initial begin
    int ncmd, ndata, first_low, last_i, k;
    clock = 0;
    rstn = 0;
    enabled_in = 1;
    array_receive_in = 64'h1000;
    data_in_valid = 0;
    data_in_half = 0;
    data_in_tag = 0;
    data_in_offset = 0;
    data_in_real_size = 0;
    data_in_payload = '0;
    write_buffer_alfull = 0;
    repeat (3) tick();
    chk("rst_cmd", write_cmd_valid, 0);
    chk("rst_data", write_data_valid, 0);
    chk("rst_done", write_job_counter_done, 0);
    chk("rst_err", error_flags, 0);
    chk("rst_alf", pairing_alfull, 0);
    rstn = 1;
    repeat (2) tick();

    // single line, exact latency
    send_beat(1'b0, 8'd3, 64'h80, 32, mkpl(8'd3, 1'b0));
    send_beat(1'b1, 8'd3, 64'h80, 32, mkpl(8'd3, 1'b1));
    data_in_valid = 0;
    tick();
    chk("lat_early", write_cmd_valid, 0);
    tick();
    chk("lat_t3", write_cmd_valid, 1);
    expect_line("single", 64'h1080, 32, mkpl(8'd3, 1'b0), mkpl(8'd3, 1'b1));
    tick();
    chk("single_idle", write_data_valid, 0);
    chk("single_done", write_job_counter_done, 32);

    // reversed / interleaved
    send_beat(1'b1, 8'd1, 64'h100, 10, mkpl(8'd1, 1'b1));
    send_beat(1'b1, 8'd2, 64'h200, 10, mkpl(8'd2, 1'b1));
    send_beat(1'b0, 8'd2, 64'h200, 10, mkpl(8'd2, 1'b0));
    send_beat(1'b0, 8'd1, 64'h100, 10, mkpl(8'd1, 1'b0));
    data_in_valid = 0;
    expect_line("tag2", 64'h1200, 10, mkpl(8'd2, 1'b0), mkpl(8'd2, 1'b1));
    expect_line("tag1", 64'h1100, 10, mkpl(8'd1, 1'b0), mkpl(8'd1, 1'b1));
    chk("inter_done", write_job_counter_done, 52);

    // backpressure: 14 queued lines
    write_buffer_alfull = 1;
    for (int i = 0; i < 14; i++) begin
      send_line(8'(i), 64'(i) * 64'h80, 1);
      if (i == 10) begin
        repeat (3) tick();
        chk("alf_11", pairing_alfull, 0);
      end
      if (i == 11) begin
        repeat (3) tick();
        chk("alf_12", pairing_alfull, 1);
      end
    end
    repeat (3) tick();
    chk("bp_hold", write_data_valid, 0);
    chk("bp_alf", pairing_alfull, 1);
    write_buffer_alfull = 0;
    ncmd = 0;
    ndata = 0;
    first_low = -1;
    last_i = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (write_cmd_valid) ncmd++;
      if (write_data_valid) begin
        ndata++;
        last_i = i;
      end
      if (i == 1) begin
        chk("bp_first_addr", write_cmd_address, 64'h1000);
        chk("bp_first_d0", write_data_payload, mkpl(8'd0, 1'b0));
      end
      if (!pairing_alfull && first_low < 0) first_low = i;
    end
    chk("bp_ncmd", ncmd, 14);
    chk("bp_ndata", ndata, 28);
    chk("bp_last", last_i, 28);
    chk("bp_alf_low", first_low, 6);
    chk("bp_done", write_job_counter_done, 66);

    // duplicate half and slot collision
    send_beat(1'b0, 8'd5, 64'h500, 7, mkpl(8'd5, 1'b0));
    send_beat(1'b0, 8'd5, 64'h500, 7, ~mkpl(8'd5, 1'b0));
    data_in_valid = 0;
    repeat (2) tick();
    chk("err_dup", error_flags, 3'b001);
    send_beat(1'b0, 8'd13, 64'hD00, 9, mkpl(8'd13, 1'b0));
    data_in_valid = 0;
    repeat (2) tick();
    chk("err_coll", error_flags, 3'b011);
    chk("coll_nopush", write_cmd_valid, 0);
    send_beat(1'b1, 8'd5, 64'h500, 7, mkpl(8'd5, 1'b1));
    data_in_valid = 0;
    expect_line("dup", 64'h1500, 7, ~mkpl(8'd5, 1'b0), mkpl(8'd5, 1'b1));
    chk("dup_done", write_job_counter_done, 73);

    // enable drop between halves, then frozen FSM
    send_beat(1'b0, 8'd6, 64'h600, 5, mkpl(8'd6, 1'b0));
    data_in_valid = 0;
    enabled_in = 0;
    tick();
    send_beat(1'b1, 8'd6, 64'h600, 5, mkpl(8'd6, 1'b1));
    data_in_valid = 0;
    repeat (5) tick();
    chk("en_ign_cmd", write_data_valid, 0);
    enabled_in = 1;
    repeat (5) tick();
    chk("en_ign_line", write_cmd_valid, 0);
    send_beat(1'b1, 8'd6, 64'h600, 5, mkpl(8'd6, 1'b1));
    data_in_valid = 0;
    k = 0;
    while (!write_cmd_valid && k < 20) begin
      tick();
      k++;
    end
    chk("en_emit0", {write_cmd_valid, write_cmd_address}, {1'b1, 64'h1600});
    enabled_in = 0;
    tick();
    chk("en_forced", {write_cmd_valid, write_data_valid, write_data_payload},
        '0);
    repeat (3) tick();
    chk("en_frz", write_data_valid, 0);
    chk("en_done", write_job_counter_done, 78);
    enabled_in = 1;
    tick();
    chk("en_resume", {write_data_valid, write_data_half}, 2'b11);
    chk("en_d1", write_data_payload, mkpl(8'd6, 1'b1));
    tick();
    chk("en_end", write_data_valid, 0);

    // FIFO overflow
    write_buffer_alfull = 1;
    for (int i = 0; i < 17; i++) send_line(8'(i), 64'(i) * 64'h80, 1);
    repeat (3) tick();
    chk("err_ovf", error_flags, 3'b111);
    chk("ovf_alf", pairing_alfull, 1);

    // reset during EMIT0
    write_buffer_alfull = 0;
    tick();
    chk("rst_pre", write_cmd_valid, 1);
    #1 rstn = 0;
    #1;
    chk("rst_mid_out", {write_cmd_valid, write_data_valid, write_data_payload},
        '0);
    chk("rst_mid_st", {pairing_alfull, error_flags, write_job_counter_done},
        '0);
    @(posedge clock);
    #1 rstn = 1;
    ndata = 0;
    repeat (20) begin
      tick();
      if (write_data_valid) ndata++;
    end
    chk("rst_noresid", ndata, 0);
    chk("rst_post_alf", pairing_alfull, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
